// File: rtl/scnn_pkg.sv
// ============================================================================
// Module : scnn_pkg
// Brief  : Shared sizes, FSM state type and index decode for the SCNN PE.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package scnn_pkg;

    localparam int ACT_W    = 16;
    localparam int OUT_W    = 32;
    localparam int MAX_ACTS = 16;
    localparam int MAX_WTS  = 9;
    localparam int ARR      = 4;
    localparam int MAX_DIM  = 4;

    localparam int IDX_W = 4;   // index into a tile of up to MAX_ACTS entries
    localparam int NA_W  = 5;   // 0..MAX_ACTS
    localparam int NW_W  = 4;   // 0..MAX_WTS

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Row-major index -> {row[1:0], col[1:0]} for a square tile of side dim.
    function automatic logic [3:0] decode_yx(input logic [IDX_W-1:0] idx,
                                             input logic [2:0]       dim);
        logic [3:0] r;
        r = '0;
        case (dim)
            3'd2:    r = {1'b0, idx[1], 1'b0, idx[0]};
            3'd3:    r = {2'(idx / 4'd3), 2'(idx % 4'd3)};
            3'd4:    r = idx;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scnn_compress.sv
// ============================================================================
// Module : scnn_compress
// Brief  : Zero-skipping compaction: packs non-zero entries below i_limit into
//          a dense list of (value, original index) plus a count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scnn_compress
    import scnn_pkg::*;
#(
    parameter int N  = 16,
    parameter int IW = $clog2(N),
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0][ACT_W-1:0] i_vals,
    input  logic [CW-1:0]           i_limit,
    output logic [N-1:0][ACT_W-1:0] o_vals,
    output logic [N-1:0][IW-1:0]    o_idx,
    output logic [CW-1:0]           o_count
);

    logic [CW-1:0] w_cnt;

    always_comb begin
        o_vals = '0;
        o_idx  = '0;
        w_cnt  = '0;
        for (int i = 0; i < N; i++) begin
            if ((CW'(i) < i_limit) && (i_vals[i] != '0)) begin
                o_vals[w_cnt[IW-1:0]] = i_vals[i];
                o_idx[w_cnt[IW-1:0]]  = IW'(i);
                w_cnt                 = w_cnt + CW'(1);
            end
        end
    end

    assign o_count = w_cnt;

endmodule

`default_nettype wire

// File: rtl/scnn_controller.sv
// ============================================================================
// Module : scnn_controller
// Brief  : Single-PE sparse convolution engine (Cartesian-product multiply,
//          scatter-accumulate). Optional macro SCNN_CTRL_SAT_EN saturates
//          accumulator updates instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scnn_controller
    import scnn_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic [MAX_ACTS-1:0][ACT_W-1:0]  input_acts,
    input  logic [3:0]                      input_dim,
    input  logic [MAX_WTS-1:0][ACT_W-1:0]   weights,
    input  logic [3:0]                      weight_dim,
    output logic [MAX_ACTS-1:0][OUT_W-1:0]  outputs
);

`ifdef SCNN_CTRL_SAT_EN
    localparam int DW = OUT_W + 4;  // headroom for 16 products in one cycle
`else
    localparam int DW = OUT_W;
`endif

    // ---------------- LOAD-side compaction and decode ----------------------
    logic                              w_dim_ok;
    logic                              w_k_ok;
    logic [NA_W-1:0]                   w_alim;
    logic [NW_W-1:0]                   w_wlim;
    logic [MAX_ACTS-1:0][ACT_W-1:0]    w_a_vals;
    logic [MAX_ACTS-1:0][IDX_W-1:0]    w_a_idx;
    logic [NA_W-1:0]                   w_na;
    logic [MAX_WTS-1:0][ACT_W-1:0]     w_w_vals;
    logic [MAX_WTS-1:0][IDX_W-1:0]     w_w_idx;
    logic [NW_W-1:0]                   w_nw;
    logic [1:0]                        w_ay [MAX_ACTS];
    logic [1:0]                        w_ax [MAX_ACTS];
    logic [1:0]                        w_wr [MAX_WTS];
    logic [1:0]                        w_ws [MAX_WTS];

    assign w_dim_ok = (input_dim != 4'd0) && (input_dim <= 4'(MAX_DIM));
    assign w_k_ok   = (weight_dim == 4'd1) || (weight_dim == 4'd3);
    // An illegal dimension empties both lists, which routes LOAD straight to DONE.
    assign w_alim   = (w_dim_ok && w_k_ok) ? ({1'b0, input_dim} * {1'b0, input_dim}) : '0;
    assign w_wlim   = (w_dim_ok && w_k_ok) ? ((weight_dim == 4'd3) ? 4'd9 : 4'd1) : '0;

    scnn_compress #(.N(MAX_ACTS)) u_act_cmp (
        .i_vals  (input_acts),
        .i_limit (w_alim),
        .o_vals  (w_a_vals),
        .o_idx   (w_a_idx),
        .o_count (w_na)
    );

    scnn_compress #(.N(MAX_WTS)) u_wt_cmp (
        .i_vals  (weights),
        .i_limit (w_wlim),
        .o_vals  (w_w_vals),
        .o_idx   (w_w_idx),
        .o_count (w_nw)
    );

    always_comb begin
        for (int i = 0; i < MAX_ACTS; i++) begin
            {w_ay[i], w_ax[i]} = decode_yx(w_a_idx[i], input_dim[2:0]);
        end
        for (int j = 0; j < MAX_WTS; j++) begin
            {w_wr[j], w_ws[j]} = decode_yx(w_w_idx[j], weight_dim[2:0]);
        end
    end

    // ---------------- Frame state ------------------------------------------
    state_t            r_state;
    logic [ACT_W-1:0]  r_a_val [MAX_ACTS];
    logic [1:0]        r_ay    [MAX_ACTS];
    logic [1:0]        r_ax    [MAX_ACTS];
    logic [ACT_W-1:0]  r_w_val [MAX_ACTS];
    logic [1:0]        r_wr    [MAX_ACTS];
    logic [1:0]        r_ws    [MAX_ACTS];
    logic [NA_W-1:0]   r_na;
    logic [NW_W-1:0]   r_nw;
    logic [2:0]        r_nag;
    logic [1:0]        r_nwg;
    logic [1:0]        r_ag;
    logic [1:0]        r_wg;
    logic [2:0]        r_dim;
    logic              r_c;
    logic [OUT_W-1:0]  r_acc   [MAX_ACTS];

    // ---------------- MULT: 4x4 products scattered to accumulators ----------
    logic [DW-1:0]        w_delta   [MAX_ACTS];
    logic [OUT_W-1:0]     w_acc_nxt [MAX_ACTS];
    logic [IDX_W-1:0]     w_ai;
    logic [IDX_W-1:0]     w_wi;
    logic signed [3:0]    w_oy;
    logic signed [3:0]    w_ox;
    logic                 w_ok;
    logic [3:0]           w_tgt;
    logic [OUT_W-1:0]     w_prod;
    logic [4:0]           w_area;

    always_comb begin
        for (int k = 0; k < MAX_ACTS; k++) begin
            w_delta[k] = '0;
        end
        w_ai   = '0;
        w_wi   = '0;
        w_oy   = '0;
        w_ox   = '0;
        w_ok   = 1'b0;
        w_tgt  = '0;
        w_prod = '0;
        for (int i = 0; i < ARR; i++) begin
            for (int j = 0; j < ARR; j++) begin
                w_ai   = {r_ag, 2'(i)};
                w_wi   = {r_wg, 2'(j)};
                w_oy   = $signed({2'b00, r_ay[w_ai]}) + $signed({3'b000, r_c})
                       - $signed({2'b00, r_wr[w_wi]});
                w_ox   = $signed({2'b00, r_ax[w_ai]}) + $signed({3'b000, r_c})
                       - $signed({2'b00, r_ws[w_wi]});
                w_ok   = ({1'b0, w_ai} < r_na) && (w_wi < r_nw)
                       && !w_oy[3] && (w_oy[2:0] < r_dim)
                       && !w_ox[3] && (w_ox[2:0] < r_dim);
                w_tgt  = ({2'b00, w_oy[1:0]} * {1'b0, r_dim}) + {2'b00, w_ox[1:0]};
                w_prod = {16'b0, r_a_val[w_ai]} * {16'b0, r_w_val[w_wi]};
                if (w_ok) begin
                    w_delta[w_tgt] = w_delta[w_tgt] + DW'(w_prod);
                end
            end
        end
    end

`ifdef SCNN_CTRL_SAT_EN
    logic [DW:0] w_sum;
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < MAX_ACTS; k++) begin
            w_sum        = (DW+1)'(r_acc[k]) + (DW+1)'(w_delta[k]);
            w_acc_nxt[k] = (|w_sum[DW:OUT_W]) ? {OUT_W{1'b1}} : w_sum[OUT_W-1:0];
        end
    end
`else
    always_comb begin
        for (int k = 0; k < MAX_ACTS; k++) begin
            w_acc_nxt[k] = r_acc[k] + w_delta[k];
        end
    end
`endif

    assign w_area = {2'b00, r_dim} * {2'b00, r_dim};

    // ---------------- FSM --------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD;
            outputs <= '0;
            r_na    <= '0;
            r_nw    <= '0;
            r_nag   <= '0;
            r_nwg   <= '0;
            r_ag    <= '0;
            r_wg    <= '0;
            r_dim   <= '0;
            r_c     <= 1'b0;
            for (int k = 0; k < MAX_ACTS; k++) begin
                r_acc[k] <= '0;
            end
        end else begin
            case (r_state)
                LOAD: begin
                    for (int i = 0; i < MAX_ACTS; i++) begin
                        r_a_val[i] <= w_a_vals[i];
                        r_ay[i]    <= w_ay[i];
                        r_ax[i]    <= w_ax[i];
                        r_acc[i]   <= '0;
                    end
                    for (int j = 0; j < MAX_WTS; j++) begin
                        r_w_val[j] <= w_w_vals[j];
                        r_wr[j]    <= w_wr[j];
                        r_ws[j]    <= w_ws[j];
                    end
                    for (int j = MAX_WTS; j < MAX_ACTS; j++) begin
                        r_w_val[j] <= '0;
                        r_wr[j]    <= '0;
                        r_ws[j]    <= '0;
                    end
                    r_na    <= w_na;
                    r_nw    <= w_nw;
                    r_nag   <= 3'((w_na + 5'd3) >> 2);
                    r_nwg   <= 2'((w_nw + 4'd3) >> 2);
                    r_ag    <= '0;
                    r_wg    <= '0;
                    r_dim   <= (w_dim_ok && w_k_ok) ? input_dim[2:0] : 3'd0;
                    r_c     <= (weight_dim == 4'd3);
                    r_state <= ((w_na == '0) || (w_nw == '0)) ? DONE : MULT;
                end
                MULT: begin
                    for (int k = 0; k < MAX_ACTS; k++) begin
                        r_acc[k] <= w_acc_nxt[k];
                    end
                    // Weight group is the inner loop, act group the outer.
                    if (r_wg == (r_nwg - 2'd1)) begin
                        r_wg <= '0;
                        if ({1'b0, r_ag} == (r_nag - 3'd1)) begin
                            r_state <= DONE;
                        end else begin
                            r_ag <= r_ag + 2'd1;
                        end
                    end else begin
                        r_wg <= r_wg + 2'd1;
                    end
                end
                DONE: begin
                    for (int k = 0; k < MAX_ACTS; k++) begin
                        outputs[k] <= (5'(k) < w_area) ? r_acc[k] : '0;
                    end
                    r_state <= LOAD;
                end
                default: r_state <= LOAD;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_scnn_controller.sv
// ============================================================================
// Module : tb_scnn_controller
// Brief  : Self-checking bench for scnn_controller: directed and random frames
//          compared against a direct correlation model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scnn_controller;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0][15:0] acts;
    logic [3:0]        dim;
    logic [8:0][15:0]  wts;
    logic [3:0]        kdim;
    logic [15:0][31:0] outs;

    int checks = 0;
    int errors = 0;
    logic [15:0][31:0] prev;
    logic [15:0][31:0] exp_o;
    int lat;

    scnn_controller dut (
        .clk        (clk),
        .rst        (rst),
        .input_acts (acts),
        .input_dim  (dim),
        .weights    (wts),
        .weight_dim (kdim),
        .outputs    (outs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Direct correlation over the current inputs plus the frame latency rule.
    task automatic model(output logic [15:0][31:0] o, output int l);
        int d, k, na, nw, c, ay, ax;
        logic [63:0] s;
        d  = int'(dim);
        k  = int'(kdim);
        na = 0;
        nw = 0;
        o  = '0;
        l  = 2;
        if (d < 1 || d > 4 || !(k == 1 || k == 3)) return;
        for (int i = 0; i < d * d; i++) if (acts[i] != 16'd0) na++;
        for (int i = 0; i < k * k; i++) if (wts[i] != 16'd0) nw++;
        c = k / 2;
        for (int y = 0; y < d; y++) begin
            for (int x = 0; x < d; x++) begin
                s = 64'd0;
                for (int r = 0; r < k; r++) begin
                    for (int q = 0; q < k; q++) begin
                        ay = y + r - c;
                        ax = x + q - c;
                        if (ay >= 0 && ay < d && ax >= 0 && ax < d)
                            s = s + {48'd0, acts[ay * d + ax]} * {48'd0, wts[r * k + q]};
                    end
                end
`ifdef SCNN_CTRL_SAT_EN
                o[y * d + x] = (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
`else
                o[y * d + x] = s[31:0];
`endif
            end
        end
        if (na != 0 && nw != 0) l = 2 + ((na + 3) / 4) * ((nw + 3) / 4);
    endtask

    // Inputs must be in place before the frame's LOAD edge (the next posedge).
    task automatic run_frame(input string name);
        model(exp_o, lat);
        for (int n = 1; n <= lat; n++) begin
            tick();
            if (n == lat - 1) check({name, " hold"}, outs, prev);
        end
        for (int k = 0; k < 16; k++)
            check($sformatf("%s out[%0d]", name, k), {480'd0, outs[k]}, {480'd0, exp_o[k]});
        prev = exp_o;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check("reset outputs", outs, '0);
        rst  = 1'b0;
        prev = '0;
    endtask

    initial begin
        rst  = 1'b1;
        acts = '0;
        wts  = '0;
        dim  = 4'd4;
        kdim = 4'd3;
        tick();
        tick();

        // Mixed sparse frame
        acts[2] = 16'd2; acts[5] = 16'd4; acts[10] = 16'd1; acts[13] = 16'd2; acts[14] = 16'd8;
        wts[0] = 16'd8; wts[1] = 16'd6; wts[2] = 16'd1; wts[4] = 16'd2; wts[7] = 16'd3;
        do_reset();
        run_frame("mixed");
        check("mixed a0",  {480'd0, outs[0]},  {480'd0, 32'd0});
        check("mixed a5",  {480'd0, outs[5]},  {480'd0, 32'd10});
        check("mixed a6",  {480'd0, outs[6]},  {480'd0, 32'd15});
        check("mixed a10", {480'd0, outs[10]}, {480'd0, 32'd58});

        // 1x1 filter; taps beyond K*K must be ignored
        acts = '0; acts[0] = 16'd5;
        wts  = '0; wts[0] = 16'd7; wts[4] = 16'd99;
        kdim = 4'd1;
        run_frame("k1");
        check("k1 a0", {480'd0, outs[0]}, {480'd0, 32'd35});

        // Zero skipping
        kdim = 4'd3;
        wts  = '0;
        for (int i = 0; i < 16; i++) acts[i] = 16'($urandom);
        run_frame("zero_w");

        // Dense
        for (int i = 0; i < 16; i++) acts[i] = 16'd1;
        for (int i = 0; i < 9; i++) wts[i] = 16'd1;
        run_frame("dense");
        check("dense a0", {480'd0, outs[0]}, {480'd0, 32'd4});
        check("dense a1", {480'd0, outs[1]}, {480'd0, 32'd6});
        check("dense a5", {480'd0, outs[5]}, {480'd0, 32'd9});

        // Reset in the middle of MULT after a completed frame
        for (int n = 0; n < 5; n++) tick();
        check("midmult hold", outs, prev);
        rst = 1'b1;
        tick();
        check("midmult reset", outs, '0);
        rst  = 1'b0;
        prev = '0;
        run_frame("dense_rerun");

        // Illegal dimensions, each following a non-zero frame
        dim = 4'd5;
        run_frame("illegal_d5");
        dim = 4'd4;
        run_frame("dense2");
        kdim = 4'd2;
        run_frame("illegal_k2");
        kdim = 4'd3;
        run_frame("dense3");
        dim = 4'd0;
        run_frame("illegal_d0");

        // Single-entry overflow: must neither wrap nor saturate
        dim  = 4'd1;
        kdim = 4'd1;
        for (int i = 0; i < 16; i++) acts[i] = 16'($urandom);
        for (int i = 0; i < 9; i++) wts[i] = 16'($urandom);
        acts[0] = 16'hFFFF;
        wts[0]  = 16'hFFFF;
        run_frame("ovf1");
        check("ovf1 a0", {480'd0, outs[0]}, {480'd0, 32'hFFFE_0001});

        // Dense all-FFFF frame: out[5] collects nine maximal products
        dim  = 4'd4;
        kdim = 4'd3;
        for (int i = 0; i < 16; i++) acts[i] = 16'hFFFF;
        for (int i = 0; i < 9; i++) wts[i] = 16'hFFFF;
        run_frame("ovf_dense");
`ifdef SCNN_CTRL_SAT_EN
        check("ovf_dense a5", {480'd0, outs[5]}, {480'd0, 32'hFFFF_FFFF});
`else
        check("ovf_dense a5", {480'd0, outs[5]}, {480'd0, 32'hFFEE_0009});
`endif

        // Random sparse frames, with an occasional reset between them
        for (int f = 0; f < 12; f++) begin
            dim  = 4'($urandom_range(1, 4));
            kdim = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd3;
            for (int i = 0; i < 16; i++)
                acts[i] = ($urandom_range(0, 1) == 0) ? 16'd0 :
                          (($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
            for (int i = 0; i < 9; i++)
                wts[i] = ($urandom_range(0, 2) == 0) ? 16'd0 :
                         (($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
            if (f % 5 == 4) do_reset();
            run_frame($sformatf("rand%0d", f));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
